// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path.
//   ALU_W        : default ALU data (yy) width
//   FLAG_CNT_W   : width of the saturating flagged-result counter
//   alu_result_t : one ALU result, {flag, data}
package alu_pkg;

    localparam int ALU_W      = 9;
    localparam int FLAG_CNT_W = 8;

    typedef struct packed {
        logic             flag;
        logic [ALU_W-1:0] data;
    } alu_result_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// Producer/consumer bus of the ALU result buffer.
//   in_valid/y/yy/in_ready            : ALU -> buffer handshake
//   out_valid/out_ready/out_flag/out_data : buffer -> consumer handshake
//   count/dropped/flag_cnt            : status and statistics
// slave is the buffer side, master is the ALU/consumer (or bench) side.
interface alu_result_buffer_if
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) ();

    logic                  in_valid;
    logic                  y;
    logic [W-1:0]          yy;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_flag;
    logic [W-1:0]          out_data;
    logic [CW-1:0]         count;
    logic                  dropped;
    logic [FLAG_CNT_W-1:0] flag_cnt;

    modport slave (
        input  in_valid, y, yy, out_ready,
        output in_ready, out_valid, out_flag, out_data, count, dropped, flag_cnt
    );

    modport master (
        output in_valid, y, yy, out_ready,
        input  in_ready, out_valid, out_flag, out_data, count, dropped, flag_cnt
    );

endinterface

// File: rtl/alu_result_ram.sv
// DEPTH x (1+W) register array holding buffered results.
//   clk   : write clock
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : {flag, data}
//   raddr : read address
//   rdata : combinational read of raddr
// Contents are deliberately not reset.
module alu_result_ram #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [W:0]    rdata
);

    logic [W:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// Show-ahead FIFO behind the ALU with overflow and flag statistics.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : alu_result_buffer_if.slave
//         in_ready  = !rst && not full (independent of out_ready)
//         out_valid = not empty, out_flag/out_data show the head, 0 when empty
//         count     = occupancy 0..DEPTH
//         dropped   = sticky, a result was offered while full
//         flag_cnt  = accepted results with y=1, saturates at all-ones
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_buffer_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         cnt;
    logic                  drop_q;
    logic [FLAG_CNT_W-1:0] fcnt;
    logic                  full, empty, in_rdy, push, pop;
    logic [W:0]            head;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    // A pop while full does not free a slot until the next cycle.
    assign in_rdy = !rst && !full;
    assign push   = bus.in_valid && in_rdy;
    assign pop    = !empty && bus.out_ready;

    alu_result_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({bus.y, bus.yy}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            drop_q <= 1'b0;
            fcnt   <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (bus.in_valid && full) drop_q <= 1'b1;
            if (push && bus.y && (fcnt != '1)) fcnt <= fcnt + FLAG_CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = !empty;
    assign bus.out_flag  = empty ? 1'b0 : head[W];
    assign bus.out_data  = empty ? '0 : head[W-1:0];
    assign bus.count     = cnt;
    assign bus.dropped   = drop_q;
    assign bus.flag_cnt  = fcnt;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized and directed bench for alu_result_buffer (W=9, DEPTH=4).
// The reference is a queue of results plus a drop flag and flag counter.
module tb_alu_result_buffer;
    import alu_pkg::*;

    localparam int W     = 9;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    alu_result_buffer_if #(.W(W), .DEPTH(DEPTH)) bus ();

    alu_result_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_result_t q[$];
    bit          m_drop;
    int          m_flags;
    int          n_vec;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, check outputs against the model, then advance the model.
    task automatic step(input bit r, input bit iv, input bit yv,
                        input logic [W-1:0] d, input bit ordy);
        alu_result_t e;
        bit          full, do_push, do_pop;
        @(negedge clk);
        rst           = r;
        bus.in_valid  = iv;
        bus.y         = yv;
        bus.yy        = d;
        bus.out_ready = ordy;
        #1;
        full = (q.size() == DEPTH);
        chk("in_ready",  32'(bus.in_ready),  32'(!r && !full));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("out_flag",  32'(bus.out_flag),  32'(q.size() != 0 ? q[0].flag : 1'b0));
        chk("out_data",  32'(bus.out_data),  32'(q.size() != 0 ? q[0].data : 9'd0));
        chk("count",     32'(bus.count),     32'(q.size()));
        chk("dropped",   32'(bus.dropped),   32'(m_drop));
        chk("flag_cnt",  32'(bus.flag_cnt),  32'(m_flags));
        @(posedge clk);
        if (r) begin
            q.delete();
            m_drop  = 1'b0;
            m_flags = 0;
        end else begin
            do_push = iv && !full;
            do_pop  = (q.size() != 0) && ordy;
            if (iv && full) m_drop = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.flag = yv;
                e.data = d;
                q.push_back(e);
                if (yv && m_flags < 255) m_flags++;
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_drop = 1'b0; m_flags = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.y = 1'b0; bus.yy = '0; bus.out_ready = 1'b0;
        @(posedge clk);

        // reset then idle
        step(1, 0, 0, 9'h000, 0);
        step(1, 1, 1, 9'h055, 1);
        step(0, 0, 0, 9'h000, 0);

        // single pass
        step(0, 1, 1, 9'h1A5, 0);
        step(0, 0, 0, 9'h000, 0);
        step(0, 0, 0, 9'h000, 1);
        step(0, 0, 0, 9'h000, 1);

        // fill and overflow, then drain
        for (int i = 1; i <= 4; i++) step(0, 1, 0, W'(i), 0);
        step(0, 1, 0, 9'd5, 0);
        step(0, 0, 0, 9'h000, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 9'h000, 1);

        // simultaneous push/pop at count=2 across pointer wrap
        step(0, 1, 0, 9'd7, 0);
        step(0, 1, 0, 9'd6, 0);
        for (int i = 5; i >= 0; i--) step(0, 1, 0, W'(i), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 9'h000, 1);

        // full with pop: pop happens, push refused, next push accepted
        for (int i = 0; i < 4; i++) step(0, 1, i[0], W'(9'h10 + i), 0);
        step(0, 1, 1, 9'h033, 1);
        step(0, 1, 1, 9'h044, 0);
        step(0, 0, 0, 9'h000, 0);

        // reset mid-stream with count=3, flag_cnt=2
        step(1, 0, 0, 9'h000, 0);
        step(0, 1, 1, 9'h101, 0);
        step(0, 1, 1, 9'h102, 0);
        step(0, 1, 0, 9'h103, 0);
        step(1, 1, 1, 9'h1FF, 1);
        step(0, 1, 0, 9'h0FF, 0);
        step(0, 0, 0, 9'h000, 1);
        step(0, 0, 0, 9'h000, 1);

        // flag counter saturation
        for (int i = 0; i < 300; i++) step(0, 1, 1, W'($urandom), 1);
        step(0, 0, 0, 9'h000, 1);
        step(0, 0, 0, 9'h000, 0);

        // random traffic with occasional reset
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), W'($urandom), $urandom_range(0, 2) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the ALU. Captures each valid ALU result (1-bit flag y, W-bit data yy) into a small synchronous FIFO.
- Presents the buffered results to the consumer over a valid/ready handshake.
- Keeps a sticky drop indicator and a saturating count of flagged results, so the bench and the system can check result ordering and loss.

Parameters:
- W, 9: result data width; must equal the ALU yy width.
- DEPTH, 4: number of FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH+1): derived width of the occupancy count; not overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU result on y/yy is valid this cycle.
- y  in  1  ALU flag output.
- yy  in  W  ALU data output.
- in_ready  out  1  buffer can accept a result this cycle.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_flag  out  1  flag of the head entry.
- out_data  out  W  data of the head entry.
- count  out  CW  current occupancy, 0..DEPTH.
- dropped  out  1  sticky: a result was offered while the buffer was full.
- flag_cnt  out  8  number of accepted results with y=1, saturating at 255.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - While rst=1 at a rising edge: count=0, rd_ptr=wr_ptr=0, dropped=0, flag_cnt=0.
  - in_ready is forced to 0 while rst is high.
  - out_valid=0, out_flag=0, out_data=0 while the buffer is empty.
  - Storage contents are not cleared.
  - Reset mid-operation discards all entries; nothing is popped or pushed in that cycle.
- Handshake signals:
  - in_ready = !rst && (count != DEPTH).
  - push = in_valid && in_ready.
  - out_valid = (count != 0).
  - pop = out_valid && out_ready.
- Show-ahead output: out_flag/out_data show storage[rd_ptr] combinationally when out_valid=1. They are forced to 0 when count=0.
- Latency: a result pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass from an empty buffer.
- Push: storage[wr_ptr] <= {y, yy}; wr_ptr increments modulo DEPTH, with natural wrap since DEPTH is a power of two.
- Pop: rd_ptr increments modulo DEPTH.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Full: in_ready=0, so no push occurs even if a pop happens in the same cycle. The freed slot becomes available the next cycle. This is the decided behaviour and keeps in_ready independent of out_ready.
- Overflow: in_valid=1 && count==DEPTH && rst=0 sets dropped=1. The result is discarded and the FIFO is unchanged. dropped clears only on reset.
- Empty: out_ready is ignored; pointers and count stay unchanged.
- flag_cnt: increments on each push with y=1 and holds at 255. A dropped result never counts.
- Data passes through unmodified; no width change from yy to out_data.

Decomposition:
- Shared package alu_pkg holds:
  - localparam ALU_W = 9, the default for W.
  - a packed struct alu_result_t with fields flag (1) and data (ALU_W).
  - a localparam FLAG_CNT_W = 8.
- Storage lives in one sub-module, alu_result_ram: a DEPTH x (1+W) register array with one synchronous write port and one combinational read port.
- Pointers, count, handshake logic and statistics stay in alu_result_buffer.

Test Plan (W=9, DEPTH=4):
- Reset then idle:
  - While rst=1: in_ready=0.
  - After rst deasserts: in_ready=1, out_valid=0, count=0, dropped=0, flag_cnt=0.
- Single pass: push {y=1, yy=9'h1A5} with out_ready=0.
  - Next cycle: out_valid=1, out_flag=1, out_data=9'h1A5, count=1, flag_cnt=1.
  - Then out_ready=1 for one cycle: count=0, out_valid=0.
- Fill and overflow:
  - Push yy=1,2,3,4 (y=0) with out_ready=0: count=4, in_ready=0.
  - A 5th push of yy=5: dropped=1, count stays 4.
  - Drain yields 1,2,3,4 in order; yy=5 never appears.
- Simultaneous push and pop at count=2: both pointers advance, count stays 2, order is preserved across pointer wrap (8 results 7..0 out in order).
- Full with pop: at count=4, in_valid=1 and out_ready=1 in the same cycle.
  - Pop occurs, no push, count=3, dropped=1.
  - The next cycle's push is accepted.
- Reset mid-stream: with count=3 and flag_cnt=2, assert rst for one cycle.
  - count=0, out_valid=0, flag_cnt=0, dropped=0.
  - The following push of yy=9'h0FF is the first result out.
